// File: rtl/apb_dpmem_arbiter.sv
// apb_dpmem_arbiter: round-robin scheduler of NUM_REQ valid/done clients onto one APB master port
// with a PREADY timeout and a registered one-cycle completion response.
module apb_dpmem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          timeout_flag,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [STRB_WIDTH-1:0]         PSTRB,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    input  logic [DATA_WIDTH-1:0]         PRDATA
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, gnt_q, gnt_d, win;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  write_q, write_d, err_q, err_d, tout_q, tout_d, found;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d, elig;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        done_d  = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        found   = 1'b0;
        win     = '0;
        // A client being acknowledged this cycle still shows valid; mask it out.
        elig    = req_valid & ~done_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SETUP;
                    gnt_d   = win;
                    ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    strb_d  = req_strb[win*STRB_WIDTH +: STRB_WIDTH];
                    write_d = req_write[win];
                    cnt_d   = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d = IDLE;
                    done_d  = NUM_REQ'(1) << gnt_q;
                    rdata_d = write_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        state_d = IDLE;
                        done_d  = NUM_REQ'(1) << gnt_q;
                        err_d   = 1'b1;
                        tout_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign PSEL         = state_q != IDLE;
    assign PENABLE      = state_q == ACCESS;
    assign PWRITE       = write_q;
    assign PADDR        = addr_q;
    assign PWDATA       = wdata_q;
    assign PSTRB        = write_q ? strb_q : '0;
    assign req_done     = done_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign timeout_flag = tout_q;
endmodule
